// File: rtl/free_list.sv
// Physical-register free list for a 4-wide rename stage.
// 64-entry circular buffer of PR numbers with head (allocate), tail (release)
// and arch_head (commit) pointers. Flush rolls head back to the committed point.
// Optional consistency checking is enabled with the FREE_LIST_CHECK_EN macro.
module free_list #(
    parameter int unsigned PR_NUM   = 65,
    parameter int unsigned ARCH_NUM = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush_stage4,
    input  logic       inst0_dest_req,
    input  logic       inst1_dest_req,
    input  logic       inst2_dest_req,
    input  logic       inst3_dest_req,
    input  logic       alloc_valid,
    output logic       alloc_ready,
    output logic [6:0] inst0_dest_PR,
    output logic [6:0] inst1_dest_PR,
    output logic [6:0] inst2_dest_PR,
    output logic [6:0] inst3_dest_PR,
    input  logic       rel0_en,
    input  logic       rel1_en,
    input  logic       rel2_en,
    input  logic       rel3_en,
    input  logic [6:0] rel0_PR,
    input  logic [6:0] rel1_PR,
    input  logic [6:0] rel2_PR,
    input  logic [6:0] rel3_PR,
    input  logic [2:0] cmt_alloc_num,
    output logic [6:0] free_cnt,
    output logic       fl_err
);

    localparam int unsigned Depth     = 64;
    localparam int unsigned ResetFree = PR_NUM - ARCH_NUM;

    logic [6:0] mem_q [Depth];
    logic [6:0] mem_d [Depth];
    logic [6:0] head_q, head_d;
    logic [6:0] tail_q, tail_d;
    logic [6:0] arch_q, arch_d;

    logic [3:0] req;
    logic [3:0] rel;
    logic [6:0] rel_pr [4];
    logic [6:0] dest   [4];
    logic [2:0] n_req;
    logic [2:0] n_rel;
    logic       alloc_fire;

    assign req    = {inst3_dest_req, inst2_dest_req, inst1_dest_req, inst0_dest_req};
    assign rel    = {rel3_en, rel2_en, rel1_en, rel0_en};
    assign rel_pr = '{rel0_PR, rel1_PR, rel2_PR, rel3_PR};

    assign free_cnt      = tail_q - head_q;
    assign inst0_dest_PR = dest[0];
    assign inst1_dest_PR = dest[1];
    assign inst2_dest_PR = dest[2];
    assign inst3_dest_PR = dest[3];

    // Compacted read-out: slot i takes the entry after all lower requesting slots.
    always_comb begin
        n_req = '0;
        for (int i = 0; i < 4; i++) begin
            dest[i] = mem_q[head_q[5:0] + 6'(n_req)];
            if (req[i]) n_req = n_req + 3'd1;
        end
    end

    // Compacted write of released PRs starting at tail.
    always_comb begin
        mem_d = mem_q;
        n_rel = '0;
        for (int i = 0; i < 4; i++) begin
            if (rel[i]) begin
                mem_d[tail_q[5:0] + 6'(n_rel)] = rel_pr[i];
                n_rel = n_rel + 3'd1;
            end
        end
    end

    // Pointer next-state; flush wins over allocation and restores the committed point.
    always_comb begin
        alloc_ready = (free_cnt >= {4'b0, n_req});
        alloc_fire  = alloc_valid & alloc_ready & ~flush_stage4;
        arch_d      = arch_q + {4'b0, cmt_alloc_num};
        tail_d      = tail_q + {4'b0, n_rel};
        head_d      = head_q;
        if (flush_stage4) begin
            head_d = arch_d;
        end else if (alloc_fire) begin
            head_d = head_q + {4'b0, n_req};
        end
    end

    // State registers; reset preloads the non-architectural PRs into the list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            arch_q <= '0;
            tail_q <= 7'(ResetFree);
            for (int k = 0; k < Depth; k++) begin
                mem_q[k] <= (k < int'(ResetFree)) ? 7'(ARCH_NUM + k) : 7'd0;
            end
        end else begin
            head_q <= head_d;
            arch_q <= arch_d;
            tail_q <= tail_d;
            mem_q  <= mem_d;
        end
    end

`ifdef FREE_LIST_CHECK_EN
    logic       err_q, err_d;
    logic [6:0] inflight;

    // Sticky flag: list overfill, or committing more than has been allocated.
    always_comb begin
        inflight = head_q - arch_q;
        err_d    = err_q
                 | (({1'b0, free_cnt} + 8'(n_rel)) > 8'(ResetFree))
                 | ({4'b0, cmt_alloc_num} > inflight);
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign fl_err = err_q;
`else
    assign fl_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed scenarios plus randomized
// rename/commit/flush traffic against a queue-based reference model.
module tb_free_list;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush;
    logic [3:0] req;
    logic       valid;
    logic       ready;
    logic [6:0] dpr [4];
    logic [3:0] rel;
    logic [6:0] rpr [4];
    logic [2:0] cmt;
    logic [6:0] free_cnt;
    logic       fl_err;

    int nchk = 0;
    int nerr = 0;

    // Reference model: every PR ever placed in the list, indexed by absolute position.
    int order[$];
    int held[$];
    int apos;
    int arch;
    bit err_m;

    always #5 clk = ~clk;

    free_list dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_stage4  (flush),
        .inst0_dest_req(req[0]),
        .inst1_dest_req(req[1]),
        .inst2_dest_req(req[2]),
        .inst3_dest_req(req[3]),
        .alloc_valid   (valid),
        .alloc_ready   (ready),
        .inst0_dest_PR (dpr[0]),
        .inst1_dest_PR (dpr[1]),
        .inst2_dest_PR (dpr[2]),
        .inst3_dest_PR (dpr[3]),
        .rel0_en       (rel[0]),
        .rel1_en       (rel[1]),
        .rel2_en       (rel[2]),
        .rel3_en       (rel[3]),
        .rel0_PR       (rpr[0]),
        .rel1_PR       (rpr[1]),
        .rel2_PR       (rpr[2]),
        .rel3_PR       (rpr[3]),
        .cmt_alloc_num (cmt),
        .free_cnt      (free_cnt),
        .fl_err        (fl_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        req   = '0;
        valid = 1'b0;
        rel   = '0;
        cmt   = '0;
        for (int i = 0; i < 4; i++) rpr[i] = '0;
    endtask

    task automatic model_reset();
        order.delete();
        held.delete();
        for (int k = 0; k < 33; k++) order.push_back(32 + k);
        for (int k = 0; k < 32; k++) held.push_back(k);
        apos  = 0;
        arch  = 0;
        err_m = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        #2;
        chk("rst_free_cnt", 32'(free_cnt), 32'd33);
        chk("rst_fl_err", 32'(fl_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Check outputs against the model, then clock once and advance the model.
    task automatic step();
        int  nreq, nrel, free, k;
        bit  rdy;
        @(negedge clk);
        nreq = 0;
        nrel = 0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) nreq++;
            if (rel[i]) nrel++;
        end
        free = order.size() - apos;
        rdy  = (free >= nreq);
        chk("free_cnt", 32'(free_cnt), 32'(free));
        chk("alloc_ready", 32'(ready), 32'(rdy));
        chk("fl_err", 32'(fl_err), 32'(err_m));
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                if (apos + k < order.size())
                    chk($sformatf("dest_PR%0d", i), 32'(dpr[i]), 32'(order[apos + k]));
                k++;
            end
        end
`ifdef FREE_LIST_CHECK_EN
        if ((free + nrel > 33) || (int'(cmt) > apos - arch)) err_m = 1'b1;
`endif
        @(posedge clk);
        if (flush) apos = arch + int'(cmt);
        else if (valid && rdy) apos = apos + nreq;
        arch = arch + int'(cmt);
        for (int i = 0; i < 4; i++) if (rel[i]) order.push_back(int'(rpr[i]));
        #1;
    endtask

    initial begin
        idle_inputs();
        model_reset();

        // Four-wide allocation straight out of reset.
        do_reset();
        req = 4'hF; valid = 1'b1;
        #1;
        chk("r28_ready", 32'(ready), 32'd1);
        chk("r28_d0", 32'(dpr[0]), 32'd32);
        chk("r28_d1", 32'(dpr[1]), 32'd33);
        chk("r28_d2", 32'(dpr[2]), 32'd34);
        chk("r28_d3", 32'(dpr[3]), 32'd35);
        step();
        idle_inputs();
        #1;
        chk("r28_free", 32'(free_cnt), 32'd29);

        // Sparse request mask is compacted.
        do_reset();
        req = 4'b1010; valid = 1'b1;
        #1;
        chk("r29_d1", 32'(dpr[1]), 32'd32);
        chk("r29_d3", 32'(dpr[3]), 32'd33);
        step();
        idle_inputs();
        #1;
        chk("r29_free", 32'(free_cnt), 32'd31);

        // Exhaustion stall, then releases visible only a cycle later.
        do_reset();
        req = 4'hF; valid = 1'b1;
        for (int c = 0; c < 8; c++) step();
        #1;
        chk("r30_stall_ready", 32'(ready), 32'd0);
        step();
        chk("r30_stall_free", 32'(free_cnt), 32'd1);
        rel = 4'b0111; rpr[0] = 7'd5; rpr[1] = 7'd6; rpr[2] = 7'd7;
        #1;
        chk("r30_nobypass", 32'(ready), 32'd0);
        step();
        rel = '0;
        #1;
        chk("r30_ready", 32'(ready), 32'd1);
        chk("r30_d0", 32'(dpr[0]), 32'd64);
        chk("r30_d1", 32'(dpr[1]), 32'd5);
        chk("r30_d2", 32'(dpr[2]), 32'd6);
        chk("r30_d3", 32'(dpr[3]), 32'd7);
        step();

        // Commit then flush restores head to the committed point.
        do_reset();
        req = 4'hF; valid = 1'b1;
        for (int c = 0; c < 3; c++) step();
        idle_inputs();
        cmt = 3'd4;
        step();
        cmt = 3'd0; flush = 1'b1;
        step();
        idle_inputs();
        #1;
        chk("r31_free", 32'(free_cnt), 32'd29);
        req = 4'hF; valid = 1'b1;
        #1;
        chk("r31_d0", 32'(dpr[0]), 32'd36);
        step();

        // Randomized rename/commit/flush traffic; runs the pointers around many times.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int inflight, ncmt, m, b;
            idle_inputs();
            req   = 4'($urandom);
            valid = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            inflight = apos - arch;
            ncmt = $urandom_range(0, (inflight < 4) ? inflight : 4);
            cmt  = 3'(ncmt);
            m = 0;
            while (m < ncmt) begin
                b = $urandom_range(0, 3);
                if (!rel[b]) begin
                    rel[b] = 1'b1;
                    m++;
                end
            end
            for (int i = 0; i < 4; i++) if (rel[i]) rpr[i] = 7'(held.pop_front());
            for (int i = 0; i < ncmt; i++) held.push_back(order[arch + i]);
            step();
        end

        // Overfill: releasing into a full list at reset.
        do_reset();
        rel[0] = 1'b1; rpr[0] = 7'd5;
        step();
        idle_inputs();
        step();
        step();
`ifdef FREE_LIST_CHECK_EN
        chk("r33_err_sticky", 32'(fl_err), 32'd1);
`else
        chk("r33_err_tied", 32'(fl_err), 32'd0);
`endif
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter PR_NUM, default 65, number of physical registers; PR indices 0..PR_NUM-1, 7-bit.
REQ-002 SHALL have parameter ARCH_NUM, default 32, number of PRs reserved at reset for the architectural mapping r_i -> PR i.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush_stage4  input  1  pipeline flush from commit.
REQ-006 SHALL have ports inst0_dest_req..inst3_dest_req  input  1 each  rename slot i needs a destination PR.
REQ-007 SHALL have port alloc_valid  input  1  rename group is valid this cycle.
REQ-008 SHALL have port alloc_ready  output  1  enough free PRs for every requesting slot.
REQ-009 SHALL have ports inst0_dest_PR..inst3_dest_PR  output  7 each  PR handed to slot i (feeds rename and PR_status).
REQ-010 SHALL have ports rel0_en..rel3_en  input  1 each, and rel0_PR..rel3_PR  input  7 each  old PRs freed at commit.
REQ-011 SHALL have port cmt_alloc_num  input  3  committed instructions (0..4) this cycle that owned a dest PR.
REQ-012 SHALL have port free_cnt  output  7  entries currently in the list.
REQ-013 SHALL have port fl_err  output  1  sticky error flag (REQ-026).

Function
REQ-014 SHALL hold the list in a 64-entry circular buffer of 7-bit PR numbers, with head, tail and arch_head pointers of 6 bits plus a wrap bit.
REQ-015 SHALL compute free_cnt = tail - head (7-bit modular).
REQ-016 SHALL compute n_req = popcount(inst*_dest_req), and drive alloc_ready = (free_cnt >= n_req) combinationally from registered state only.
REQ-017 SHALL drive inst_i_dest_PR = entry[head + number of requesting slots below i], compacted; value is don't-care when slot i is not requesting.
REQ-018 SHALL, on alloc_valid & alloc_ready & !flush_stage4, advance head by n_req at the clock edge; outputs are valid in the same cycle, with zero latency.
REQ-019 SHALL compute n_rel = popcount(rel*_en), write rel PRs compacted at tail, tail+1, ... in slot order, and advance tail by n_rel each cycle, including the flush cycle.
REQ-020 SHALL advance arch_head by cmt_alloc_num each cycle, including the flush cycle.
REQ-021 SHALL, on flush_stage4, set head to arch_head + cmt_alloc_num (the next arch_head value); allocation is suppressed in that cycle.
REQ-022 SHALL NOT let releases in a cycle be visible to alloc_ready or the dest_PR outputs until the following cycle; there is no same-cycle bypass.
REQ-023 SHALL treat alloc_valid with n_req = 0 as a no-op.
REQ-024 SHALL hold head when alloc_ready = 0; the requester stalls and retries with the same request.

Reset
REQ-025 SHALL, while rst_n = 0: set head = arch_head = 0, tail = PR_NUM-ARCH_NUM (33), entry[k] = ARCH_NUM+k for k = 0..32, other entries 0, free_cnt = 33, and fl_err = 0; a reset mid-operation discards all in-flight state.

Configuration
REQ-026 SHALL, with FREE_LIST_CHECK_EN defined, set fl_err sticky (cleared only by reset) when free_cnt + n_rel > PR_NUM-ARCH_NUM, or when cmt_alloc_num exceeds head - arch_head.
REQ-027 SHALL, without FREE_LIST_CHECK_EN, keep the fl_err port present and tie it to 0 with no check logic.

Verification
REQ-028 Reset, then all four dest_req set with alloc_valid -> alloc_ready = 1, dest_PR = 32,33,34,35; next cycle free_cnt = 29.
REQ-029 Requests on slots 1 and 3 only -> inst1_dest_PR = 32, inst3_dest_PR = 33; head advances by 2.
REQ-030 Allocate 8 cycles x 4 (32 PRs), then request 4 -> alloc_ready = 0, head unchanged; release 3 PRs (5,6,7) -> next cycle alloc_ready = 1 with dest_PR 64,5,6,7.
REQ-031 Allocate 12, commit cmt_alloc_num = 4, then flush_stage4 -> head = 4, free_cnt = 29, next allocation returns PR 36 first.
REQ-032 Pointer wrap: more than 64 cumulative alloc/release cycles -> PR order is preserved across index 63 -> 0, and free_cnt stays consistent.
REQ-033 With FREE_LIST_CHECK_EN, release 1 PR at reset (free_cnt = 33) -> fl_err = 1 and stays 1; without the macro -> fl_err stays 0.
